// File: rtl/mem_bus_arbiter_pkg.sv
// Shared widths, FSM encodings and request payload type for the two-master memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned CNT_W  = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    typedef struct packed {
        logic              instr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

    function automatic mem_req_t pick_req(input logic sel, input mem_req_t r0, input mem_req_t r1);
        return sel ? r1 : r0;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// picorv32-style native memory bus: request fields from the master, ready/rdata back from the slave.
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    logic              valid;
    logic              instr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (output valid, instr, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, instr, addr, wdata, wstrb, output ready, rdata);

endinterface

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// Counts stalled BUSY cycles; flags expiry on the last allowed cycle so the arbiter can force completion.
module mem_bus_arbiter_bus_watchdog
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire_c
);

    logic [CNT_W-1:0] r_cnt;

    assign o_expire_c = i_enable && (r_cnt == CNT_W'(TIMEOUT - 1));

    // Counter restarts from zero on expiry so the following ERR cycle sees a clean count.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= o_expire_c ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one native memory bus between CPU (M0) and DMA/debug (M1),
// with a watchdog that completes hung accesses with an error word and logs the first failing address.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned       TIMEOUT   = 16,
    parameter logic [DATA_W-1:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.slave  m0_bus,
    mem_bus_arbiter_if.slave  m1_bus,
    mem_bus_arbiter_if.master s_bus,
    output logic              o_grant_id,
    output logic              o_busy,
    output logic              o_bus_err,
    output logic [ADDR_W-1:0] o_err_addr,
    input  logic              i_bus_err_clr
);

    logic [1:0]        r_state;
    logic              r_grant_id;
    logic              r_last_grant;
    logic              r_bus_err;
    logic [ADDR_W-1:0] r_err_addr;

    logic [1:0]        w_next_state;
    logic              w_s_valid;
    logic              w_done;
    logic              w_err_cycle;
    logic              w_req_any;
    logic              w_req_both;
    logic              w_winner;
    logic              w_wd_en;
    logic              w_wd_expire;
    logic              w_m_ready;
    logic [DATA_W-1:0] w_m_rdata;
    logic              w_m0_ready;
    logic              w_m1_ready;
    mem_req_t          w_req0;
    mem_req_t          w_req1;
    mem_req_t          w_sel_req;

    assign w_req_any  = m0_bus.valid | m1_bus.valid;
    assign w_req_both = m0_bus.valid & m1_bus.valid;
    assign w_winner   = w_req_both ? ~r_last_grant : m1_bus.valid;

    assign w_req0 = '{instr: m0_bus.instr, addr: m0_bus.addr, wdata: m0_bus.wdata, wstrb: m0_bus.wstrb};
    assign w_req1 = '{instr: m1_bus.instr, addr: m1_bus.addr, wdata: m1_bus.wdata, wstrb: m1_bus.wstrb};
    assign w_sel_req = pick_req(r_grant_id, w_req0, w_req1);

    assign w_wd_en = (r_state == ST_BUSY) && !s_bus.ready;

    mem_bus_arbiter_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (~w_wd_en),
        .i_enable   (w_wd_en),
        .o_expire_c (w_wd_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_s_valid    = 1'b0;
        w_done       = 1'b0;
        w_err_cycle  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_s_valid = 1'b1;
                if (s_bus.ready) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_wd_expire) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_ERR: begin
                w_err_cycle  = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Completion is suppressed while reset is asserted so an aborted access never reports back.
    assign w_m_ready  = (w_done | w_err_cycle) & ~reset;
    assign w_m_rdata  = w_err_cycle ? ERR_RDATA : s_bus.rdata;
    assign w_m0_ready = w_m_ready & ~r_grant_id;
    assign w_m1_ready = w_m_ready &  r_grant_id;

    assign m0_bus.ready = w_m0_ready;
    assign m0_bus.rdata = w_m0_ready ? w_m_rdata : '0;
    assign m1_bus.ready = w_m1_ready;
    assign m1_bus.rdata = w_m1_ready ? w_m_rdata : '0;

    assign s_bus.valid = w_s_valid;
    assign s_bus.instr = w_sel_req.instr;
    assign s_bus.addr  = w_sel_req.addr;
    assign s_bus.wdata = w_sel_req.wdata;
    assign s_bus.wstrb = w_sel_req.wstrb;

    // Grant bookkeeping and sticky error log; an error in the clear cycle takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b1;
            r_bus_err    <= 1'b0;
            r_err_addr   <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_req_any) begin
                r_grant_id <= w_winner;
                if (w_req_both) begin
                    r_last_grant <= w_winner;
                end
            end
            if (w_err_cycle) begin
                r_bus_err <= 1'b1;
                if (!r_bus_err || i_bus_err_clr) begin
                    r_err_addr <= w_sel_req.addr;
                end
            end else if (i_bus_err_clr) begin
                r_bus_err  <= 1'b0;
                r_err_addr <= '0;
            end
        end
    end

    assign o_grant_id = r_grant_id;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_bus_err  = r_bus_err;
    assign o_err_addr = r_err_addr;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a transaction-level reference model.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int unsigned TIMEOUT  = 16;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bus_err_clr = 1'b0;
    logic        grant_id;
    logic        busy;
    logic        bus_err;
    logic [31:0] err_addr;

    mem_bus_arbiter_if m0_if ();
    mem_bus_arbiter_if m1_if ();
    mem_bus_arbiter_if s_if ();

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .TIMEOUT   (TIMEOUT),
        .ERR_RDATA (ERR_WORD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m0_bus        (m0_if),
        .m1_bus        (m1_if),
        .s_bus         (s_if),
        .o_grant_id    (grant_id),
        .o_busy        (busy),
        .o_bus_err     (bus_err),
        .o_err_addr    (err_addr),
        .i_bus_err_clr (bus_err_clr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: round-robin pointer and error log
    logic        mdl_last;
    logic        mdl_bus_err;
    logic [31:0] mdl_err_addr;

    // Pending master requests
    logic        mv [2];
    logic        mi [2];
    logic [31:0] ma [2];
    logic [31:0] mw [2];
    logic [3:0]  ms [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_masters();
        m0_if.valid = mv[0]; m0_if.instr = mi[0]; m0_if.addr = ma[0]; m0_if.wdata = mw[0]; m0_if.wstrb = ms[0];
        m1_if.valid = mv[1]; m1_if.instr = mi[1]; m1_if.addr = ma[1]; m1_if.wdata = mw[1]; m1_if.wstrb = ms[1];
    endtask

    task automatic set_req(input int i, input logic instr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
        mv[i] = 1'b1; mi[i] = instr; ma[i] = addr; mw[i] = wdata; ms[i] = wstrb;
        drive_masters();
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)));
    endtask

    task automatic drop_req(input int i);
        mv[i] = 1'b0;
        drive_masters();
    endtask

    function automatic logic ready_of(input int i);
        return (i == 1) ? m1_if.ready : m0_if.ready;
    endfunction

    function automatic logic [31:0] rdata_of(input int i);
        return (i == 1) ? m1_if.rdata : m0_if.rdata;
    endfunction

    function automatic logic valid_of(input int i);
        return (i == 1) ? m1_if.valid : m0_if.valid;
    endfunction

    task automatic model_reset();
        mdl_last = 1'b1; mdl_bus_err = 1'b0; mdl_err_addr = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mv[0] = 1'b0; mv[1] = 1'b0;
        drive_masters();
        s_if.ready = 1'b0; s_if.rdata = '0;
        tick(); tick();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_svalid", 32'(s_if.valid), 0);
        chk("rst_rdy0", 32'(m0_if.ready), 0);
        chk("rst_rdy1", 32'(m1_if.ready), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        chk("rst_err_addr", err_addr, 0);
        model_reset();
        tick();
        reset = 1'b0;
    endtask

    // One complete transaction starting from an IDLE cycle; lat < 0 means the slave never answers.
    task automatic serve(input int lat, input logic late, input logic clr_in_err, output int w);
        logic        done;
        logic        finished;
        logic [31:0] rd;
        if (mv[0] && mv[1]) begin
            w = mdl_last ? 0 : 1;
            mdl_last = (w == 1);
        end else begin
            w = mv[1] ? 1 : 0;
        end
        s_if.ready = 1'($urandom_range(0, 1));
        s_if.rdata = $urandom;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_svalid", 32'(s_if.valid), 0);
        chk("idle_rdy0", 32'(m0_if.ready), 0);
        chk("idle_rdy1", 32'(m1_if.ready), 0);
        finished = 1'b0;
        for (int k = 0; k < int'(TIMEOUT) && !finished; k++) begin
            tick();
            done = (lat == k);
            rd = $urandom;
            s_if.ready = done;
            s_if.rdata = rd;
            @(negedge clk);
            chk("busy_busy", 32'(busy), 1);
            chk("busy_svalid", 32'(s_if.valid), 1);
            chk("busy_grant", 32'(grant_id), 32'(w));
            chk("busy_saddr", s_if.addr, ma[w]);
            chk("busy_swdata", s_if.wdata, mw[w]);
            chk("busy_sinstr_wstrb", 32'({s_if.instr, s_if.wstrb}), 32'({mi[w], ms[w]}));
            chk("valid_held", 32'(valid_of(w)), 1);
            chk("busy_rdy_gnt", 32'(ready_of(w)), 32'(done));
            chk("busy_rdata_gnt", rdata_of(w), done ? rd : 32'h0);
            chk("busy_rdy_other", 32'(ready_of(1 - w)), 0);
            chk("busy_rdata_other", rdata_of(1 - w), 0);
            finished = done;
        end
        if (!finished) begin
            tick();
            s_if.ready = late;
            s_if.rdata = $urandom;
            bus_err_clr = clr_in_err;
            @(negedge clk);
            chk("err_svalid", 32'(s_if.valid), 0);
            chk("err_busy", 32'(busy), 1);
            chk("err_rdy_gnt", 32'(ready_of(w)), 1);
            chk("err_rdata_gnt", rdata_of(w), ERR_WORD);
            chk("err_rdy_other", 32'(ready_of(1 - w)), 0);
            if (!mdl_bus_err || clr_in_err) mdl_err_addr = ma[w];
            mdl_bus_err = 1'b1;
        end
        tick();
        s_if.ready = 1'b0;
        bus_err_clr = 1'b0;
        chk("post_bus_err", 32'(bus_err), 32'(mdl_bus_err));
        chk("post_err_addr", err_addr, mdl_err_addr);
    endtask

    task automatic pulse_clr();
        bus_err_clr = 1'b1;
        @(negedge clk);
        chk("clr_busy", 32'(busy), 0);
        tick();
        bus_err_clr = 1'b0;
        mdl_bus_err = 1'b0;
        mdl_err_addr = '0;
        chk("clr_bus_err", 32'(bus_err), 0);
        chk("clr_err_addr", err_addr, 0);
    endtask

    initial begin
        int w;
        int lat;
        for (int i = 0; i < 2; i++) begin
            mv[i] = 1'b0; mi[i] = 1'b0; ma[i] = '0; mw[i] = '0; ms[i] = '0;
        end
        drive_masters();
        s_if.ready = 1'b0;
        s_if.rdata = '0;
        model_reset();
        do_reset();

        // T1: lone M0 read, slave answers one cycle after s_valid
        set_req(0, 1'b0, 32'h0000_0010, 32'h0, 4'b0000);
        serve(1, 1'b0, 1'b0, w);
        drop_req(0);

        // T2: simultaneous requests after reset alternate M0, M1, M0, M1
        do_reset();
        rand_req(0);
        rand_req(1);
        serve(1, 1'b0, 1'b0, w);
        rand_req(w);
        serve(0, 1'b0, 1'b0, w);
        rand_req(w);
        serve(2, 1'b0, 1'b0, w);
        drop_req(w);
        serve(1, 1'b0, 1'b0, w);
        drop_req(w);

        // T3: M1 byte write, fields must follow M1 through the whole BUSY phase
        set_req(1, 1'b0, 32'h0010_0000, 32'h0000_00A5, 4'b0001);
        serve(3, 1'b0, 1'b0, w);
        drop_req(w);

        // T4: hung slave forces an error completion
        set_req(0, 1'b0, 32'h0000_2000, 32'h0, 4'b0000);
        serve(-1, 1'b1, 1'b0, w);
        drop_req(w);
        chk("t4_bus_err", 32'(bus_err), 1);
        chk("t4_err_addr", err_addr, 32'h0000_2000);

        // T5: first error kept, clear, then error and clear in the same cycle
        set_req(1, 1'b1, 32'h0000_3000, 32'h0, 4'b0000);
        serve(-1, 1'b0, 1'b0, w);
        drop_req(w);
        chk("t5_err_addr_kept", err_addr, 32'h0000_2000);
        pulse_clr();
        set_req(0, 1'b0, 32'h0000_4000, 32'h1234_5678, 4'b1111);
        serve(-1, 1'b1, 1'b0, w);
        drop_req(w);
        set_req(1, 1'b0, 32'h0000_5000, 32'h0, 4'b0000);
        serve(-1, 1'b0, 1'b1, w);
        drop_req(w);
        chk("t5_set_wins_err", 32'(bus_err), 1);
        chk("t5_set_wins_addr", err_addr, 32'h0000_5000);

        // T6: reset in the middle of a transaction, with s_ready in the reset cycle and after
        set_req(0, 1'b0, 32'h0000_6000, 32'h0, 4'b0000);
        @(negedge clk);
        chk("t6_idle", 32'(busy), 0);
        tick();
        s_if.ready = 1'b0;
        @(negedge clk);
        chk("t6_svalid", 32'(s_if.valid), 1);
        tick();
        reset = 1'b1;
        s_if.ready = 1'b1;
        s_if.rdata = $urandom;
        @(negedge clk);
        chk("t6_rdy_in_reset", 32'(m0_if.ready), 0);
        tick();
        reset = 1'b0;
        drop_req(0);
        model_reset();
        @(negedge clk);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_svalid_low", 32'(s_if.valid), 0);
        chk("t6_late_rdy0", 32'(m0_if.ready), 0);
        chk("t6_late_rdy1", 32'(m1_if.ready), 0);
        chk("t6_bus_err", 32'(bus_err), 0);
        tick();
        s_if.ready = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            if (!mv[0] && !mv[1]) rand_req($urandom_range(0, 1));
            if (!mv[0] && $urandom_range(0, 2) == 0) rand_req(0);
            if (!mv[1] && $urandom_range(0, 2) == 0) rand_req(1);
            lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
            serve(lat, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), w);
            if ($urandom_range(0, 3) == 0) drop_req(w);
            else rand_req(w);
            if (!mv[0] && !mv[1] && $urandom_range(0, 1) == 0) pulse_clr();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
